// File: rtl/hdmi_island_scheduler.sv
// HDMI data-island scheduler: opens one island per line, arbitrates packet sources, sequences preamble/guard/packet periods.
// Defining HDMI_AUDIO_INFOFRAME_EN adds the once-per-frame Audio InfoFrame source.
module hdmi_island_scheduler #(
    parameter int ISLAND_X    = 10,
    parameter int MAX_PACKETS = 2,
    parameter int ACR_LINES   = 8
) (
    input  logic       clk_pix,
    input  logic       rst_in,
    input  logic [9:0] cx,
    input  logic [9:0] cy,
    input  logic       audio_req,
    output logic       audio_ack,
    output logic [1:0] mode,
    output logic [2:0] packet_sel,
    output logic       packet_start,
    output logic [4:0] pkt_cnt
);

    typedef enum logic [2:0] {
        S_IDLE, S_PREAMBLE, S_GUARD_LEAD, S_PACKET, S_GUARD_TRAIL
    } state_t;

    typedef enum logic [1:0] {
        MODE_CTRL     = 2'd0,
        MODE_PREAMBLE = 2'd1,
        MODE_GUARD    = 2'd2,
        MODE_DATA     = 2'd3
    } mode_t;

    typedef enum logic [2:0] {
        SEL_NULL  = 3'd0,
        SEL_AUDIO = 3'd1,
        SEL_ACR   = 3'd2,
        SEL_AVI   = 3'd3,
        SEL_AINFO = 3'd4
    } sel_t;

    localparam int                LINE_W    = (ACR_LINES > 1) ? $clog2(ACR_LINES) : 1;
    localparam logic [9:0]        ISLAND_CX = 10'(ISLAND_X);
    localparam logic [4:0]        PKT_LIMIT = 5'(MAX_PACKETS);
    localparam logic [LINE_W-1:0] LINE_LAST = LINE_W'(ACR_LINES - 1);

    state_t            state, state_next;
    logic [4:0]        phase_cnt, phase_next;
    logic [4:0]        pkts_sent, pkts_next;
    logic [LINE_W-1:0] line_cnt;
    logic              acr_pend, avi_pend;
    logic              any_pend, enter_packet;
    sel_t              grant;
    mode_t             mode_next;

    logic island_open, line_tick, line_wrap, frame_start;
    assign island_open = (cx == ISLAND_CX);
    assign line_tick   = (cx == 10'd0);
    assign line_wrap   = line_tick && (line_cnt == LINE_LAST);
    assign frame_start = line_tick && (cy == 10'd0);

`ifdef HDMI_AUDIO_INFOFRAME_EN
    logic ainfo_pend;

    always_ff @(posedge clk_pix or negedge rst_in) begin
        if (!rst_in) ainfo_pend <= 1'b0;
        else         ainfo_pend <= frame_start | (ainfo_pend & ~(enter_packet && grant == SEL_AINFO));
    end

    assign any_pend = audio_req | acr_pend | avi_pend | ainfo_pend;
`else
    assign any_pend = audio_req | acr_pend | avi_pend;
`endif

    // Fixed priority; the null packet is granted only when nothing is pending.
    always_comb begin
        grant = SEL_NULL;
        if (audio_req)     grant = SEL_AUDIO;
        else if (acr_pend) grant = SEL_ACR;
        else if (avi_pend) grant = SEL_AVI;
`ifdef HDMI_AUDIO_INFOFRAME_EN
        else if (ainfo_pend) grant = SEL_AINFO;
`endif
    end

    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
    always_comb begin
        state_next   = state;
        phase_next   = phase_cnt + 5'd1;
        pkts_next    = pkts_sent;
        enter_packet = 1'b0;
        case (state)
            S_IDLE: begin
                phase_next = '0;
                pkts_next  = '0;
                if (island_open && any_pend) state_next = S_PREAMBLE;
            end
            S_PREAMBLE: begin
                if (phase_cnt == 5'd7) begin
                    state_next = S_GUARD_LEAD;
                    phase_next = '0;
                end
            end
            S_GUARD_LEAD: begin
                if (phase_cnt == 5'd1) begin
                    state_next   = S_PACKET;
                    phase_next   = '0;
                    enter_packet = 1'b1;
                end
            end
            S_PACKET: begin
                if (phase_cnt == 5'd31) begin
                    phase_next = '0;
                    if (pkts_sent < PKT_LIMIT && any_pend) enter_packet = 1'b1;
                    else                                   state_next   = S_GUARD_TRAIL;
                end
            end
            S_GUARD_TRAIL: begin
                if (phase_cnt == 5'd1) begin
                    state_next = S_IDLE;
                    phase_next = '0;
                end
            end
            default: state_next = S_IDLE;
        endcase
        if (enter_packet) pkts_next = pkts_sent + 5'd1;
    end

    always_comb begin
        mode_next = MODE_CTRL;
        case (state_next)
            S_PREAMBLE:                  mode_next = MODE_PREAMBLE;
            S_GUARD_LEAD, S_GUARD_TRAIL: mode_next = MODE_GUARD;
            S_PACKET:                    mode_next = MODE_DATA;
            default:                     mode_next = MODE_CTRL;
        endcase
    end

    // NOTE: non-blocking assignments so every register samples the pre-edge values of the others.
    always_ff @(posedge clk_pix or negedge rst_in) begin
        if (!rst_in) begin
            state        <= S_IDLE;
            phase_cnt    <= '0;
            pkts_sent    <= '0;
            line_cnt     <= '0;
            acr_pend     <= 1'b0;
            avi_pend     <= 1'b0;
            mode         <= MODE_CTRL;
            packet_sel   <= SEL_NULL;
            packet_start <= 1'b0;
            audio_ack    <= 1'b0;
            pkt_cnt      <= '0;
        end else begin
            state     <= state_next;
            phase_cnt <= phase_next;
            pkts_sent <= pkts_next;
            if (line_tick) line_cnt <= line_wrap ? '0 : line_cnt + 1'b1;
            // A set event in the same cycle as the grant clear wins.
            acr_pend     <= line_wrap   | (acr_pend & ~(enter_packet && grant == SEL_ACR));
            avi_pend     <= frame_start | (avi_pend & ~(enter_packet && grant == SEL_AVI));
            mode         <= mode_next;
            packet_start <= enter_packet;
            audio_ack    <= enter_packet && (grant == SEL_AUDIO);
            if (state_next != S_PACKET) packet_sel <= SEL_NULL;
            else if (enter_packet)      packet_sel <= grant;
            pkt_cnt <= (state_next == S_PACKET) ? phase_next : '0;
        end
    end

endmodule

// File: tb/tb_hdmi_island_scheduler.sv
// Directed bench for hdmi_island_scheduler: drives pixel timing lines and compares run-length mode traces and packet logs.
module tb_hdmi_island_scheduler;

`ifdef HDMI_AUDIO_INFOFRAME_EN
    localparam int AINFO_ON = 1;
`else
    localparam int AINFO_ON = 0;
`endif
    localparam int H_TOTAL = 100;

    logic       clk_pix = 1'b0;
    logic       rst_in;
    logic [9:0] cx, cy;
    logic       audio_req;

    logic       ack0, ack1, ps0, ps1;
    logic [1:0] mode0, mode1;
    logic [2:0] sel0, sel1;
    logic [4:0] pc0, pc1;

    hdmi_island_scheduler dut (
        .clk_pix(clk_pix), .rst_in(rst_in), .cx(cx), .cy(cy), .audio_req(audio_req),
        .audio_ack(ack0), .mode(mode0), .packet_sel(sel0), .packet_start(ps0), .pkt_cnt(pc0)
    );

    hdmi_island_scheduler #(.MAX_PACKETS(1)) dut_mp1 (
        .clk_pix(clk_pix), .rst_in(rst_in), .cx(cx), .cy(cy), .audio_req(audio_req),
        .audio_ack(ack1), .mode(mode1), .packet_sel(sel1), .packet_start(ps1), .pkt_cnt(pc1)
    );

    always #5 clk_pix = ~clk_pix;

    logic       use_mp1 = 1'b0;
    logic [1:0] obs_mode;
    logic [2:0] obs_sel;
    logic [4:0] obs_pc;
    logic       obs_ps, obs_ack;
    assign obs_mode = use_mp1 ? mode1 : mode0;
    assign obs_sel  = use_mp1 ? sel1  : sel0;
    assign obs_pc   = use_mp1 ? pc1   : pc0;
    assign obs_ps   = use_mp1 ? ps1   : ps0;
    assign obs_ack  = use_mp1 ? ack1  : ack0;

    int checks = 0;
    int errors = 0;
    int viol   = 0;
    int prev_pc = 0;
    int audio_pol = 0;  // 0 off, 1 held, 2 high only at cx==10
    int run_mode[$];
    int run_len[$];
    int sel_log[$];
    int ack_cnt = 0;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_log();
        run_mode.delete();
        run_len.delete();
        sel_log.delete();
        ack_cnt = 0;
    endtask

    task automatic record();
        int m;
        m = int'(obs_mode);
        if (run_mode.size() == 0 || run_mode[run_mode.size()-1] != m) begin
            run_mode.push_back(m);
            run_len.push_back(1);
        end else begin
            run_len[run_len.size()-1] = run_len[run_len.size()-1] + 1;
        end
        if (obs_ps) sel_log.push_back(int'(obs_sel));
        if (obs_ack) ack_cnt++;
        if (m != 3 && obs_pc != 5'd0) viol++;
        if (obs_ps && (m != 3 || obs_pc != 5'd0)) viol++;
        if (m == 3 && obs_pc == 5'd0 && !obs_ps) viol++;
        if (m == 3 && !obs_ps && int'(obs_pc) != ((prev_pc + 1) % 32)) viol++;
        if (obs_ack && (!obs_ps || obs_sel != 3'd1)) viol++;
        if (AINFO_ON == 0 && obs_sel == 3'd4) viol++;
        prev_pc = int'(obs_pc);
    endtask

    task automatic tick(input int x, input int y);
        cx = 10'(x);
        cy = 10'(y);
        audio_req = (audio_pol == 1) || (audio_pol == 2 && x == 10);
        @(posedge clk_pix);
        #1;
        record();
    endtask

    task automatic run_line(input int y);
        for (int x = 0; x < H_TOTAL; x++) tick(x, y);
    endtask

    task automatic do_reset();
        rst_in    = 1'b0;
        audio_req = 1'b0;
        cx        = 10'd500;
        cy        = 10'd500;
        repeat (3) @(posedge clk_pix);
        #2 rst_in = 1'b1;
        clear_log();
    endtask

    // Expected run-length trace: idle, 8 preamble, 2 guard, 32 per packet, 2 guard, idle.
    task automatic check_runs(input string tag, input int start, input int npkts, input int total);
        int em[$];
        int el[$];
        int tail;
        if (npkts == 0) begin
            em.push_back(0); el.push_back(total);
        end else begin
            tail = total - start - 12 - 32 * npkts;
            em.push_back(0); el.push_back(start);
            em.push_back(1); el.push_back(8);
            em.push_back(2); el.push_back(2);
            em.push_back(3); el.push_back(32 * npkts);
            em.push_back(2); el.push_back(2);
            if (tail > 0) begin em.push_back(0); el.push_back(tail); end
        end
        check({tag, "_nruns"}, run_mode.size(), em.size());
        for (int i = 0; i < em.size() && i < run_mode.size(); i++) begin
            check($sformatf("%s_run%0d_mode", tag, i), run_mode[i], em[i]);
            check($sformatf("%s_run%0d_len", tag, i), run_len[i], el[i]);
        end
    endtask

    task automatic check_sels(input string tag, input int n, input int s0, input int s1);
        check({tag, "_npkt"}, sel_log.size(), n);
        if (n > 0 && sel_log.size() > 0) check({tag, "_sel0"}, sel_log[0], s0);
        if (n > 1 && sel_log.size() > 1) check({tag, "_sel1"}, sel_log[1], s1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        int found;
        int resume;
        int n_avi, n_acr, n_ainfo, n_null;

        // Reset values
        rst_in = 1'b0; audio_req = 1'b0; cx = 10'd500; cy = 10'd500;
        @(posedge clk_pix); #1;
        check("rst_mode", int'(mode0), 0);
        check("rst_sel", int'(sel0), 0);
        check("rst_start", int'(ps0), 0);
        check("rst_ack", int'(ack0), 0);
        check("rst_pkt_cnt", int'(pc0), 0);

        // Audio held: two audio packets back to back, latency 1 clock from cx==10
        do_reset();
        audio_pol = 1;
        run_line(1);
        check_runs("audio2", 10, 2, H_TOTAL);
        check_sels("audio2", 2, 1, 1);
        check("audio2_acks", ack_cnt, 2);

        // Audio only at cx==10: one null packet, no ack
        do_reset();
        audio_pol = 2;
        run_line(1);
        check_runs("null", 10, 1, H_TOTAL);
        check_sels("null", 1, 0, 0);
        check("null_acks", ack_cnt, 0);

        // Frame start: AVI (then Audio InfoFrame when enabled); next line stays idle
        do_reset();
        audio_pol = 0;
        run_line(0);
        check_runs("frame", 10, 1 + AINFO_ON, H_TOTAL);
        check_sels("frame", 1 + AINFO_ON, 3, 4);
        clear_log();
        run_line(1);
        check_runs("frame_next", 0, 0, H_TOTAL);
        check("frame_next_npkt", sel_log.size(), 0);

        // cx==10 repeated while the island is running is ignored
        do_reset();
        audio_pol = 1;
        for (int x = 0; x < 10; x++) tick(x, 1);
        repeat (5) tick(10, 1);
        for (int x = 11; x < H_TOTAL; x++) tick(x, 1);
        check_runs("rematch", 10, 2, H_TOTAL + 4);
        check_sels("rematch", 2, 1, 1);

        // MAX_PACKETS=1: audio wins the island on the ACR wrap line, ACR goes next line
        use_mp1 = 1'b1;
        do_reset();
        audio_pol = 0;
        for (int y = 1; y <= 7; y++) run_line(y);
        check("mp1_quiet_npkt", sel_log.size(), 0);
        clear_log();
        audio_pol = 1;
        run_line(8);
        check_runs("mp1_audio", 10, 1, H_TOTAL);
        check_sels("mp1_audio", 1, 1, 0);
        check("mp1_audio_acks", ack_cnt, 1);
        clear_log();
        audio_pol = 0;
        run_line(9);
        check_runs("mp1_acr", 10, 1, H_TOTAL);
        check_sels("mp1_acr", 1, 2, 0);
        check("mp1_acr_acks", ack_cnt, 0);
        use_mp1 = 1'b0;

        // Reset in the middle of a packet aborts the island at once
        do_reset();
        audio_pol = 1;
        found = -1;
        for (int x = 0; x < H_TOTAL; x++) begin
            tick(x, 1);
            if (obs_mode == 2'd3 && obs_pc == 5'd15) begin
                found = x;
                break;
            end
        end
        check("abort_pkt15_cx", found, 35);
        if (found < 0) found = 35;
        #2 rst_in = 1'b0;
        #1;
        check("abort_mode", int'(mode0), 0);
        check("abort_pkt_cnt", int'(pc0), 0);
        check("abort_sel", int'(sel0), 0);
        check("abort_ack", int'(ack0), 0);
        tick(found + 1, 1);
        tick(found + 2, 1);
        check("abort_held_mode", int'(mode0), 0);
        #2 rst_in = 1'b1;
        clear_log();
        resume = found + 3;
        for (int x = resume; x < H_TOTAL; x++) tick(x, 1);
        run_line(2);
        check_runs("after_abort", (H_TOTAL - resume) + 10, 2, (H_TOTAL - resume) + H_TOTAL);
        check("after_abort_acks", ack_cnt, 2);

        // Three frames of four lines: AVI once per frame, one ACR, Audio InfoFrame only if enabled
        do_reset();
        audio_pol = 0;
        for (int f = 0; f < 3; f++)
            for (int y = 0; y < 4; y++) run_line(y);
        n_avi = 0; n_acr = 0; n_ainfo = 0; n_null = 0;
        foreach (sel_log[i]) begin
            if (sel_log[i] == 3) n_avi++;
            if (sel_log[i] == 2) n_acr++;
            if (sel_log[i] == 4) n_ainfo++;
            if (sel_log[i] == 0) n_null++;
        end
        check("frames_avi", n_avi, 3);
        check("frames_acr", n_acr, 1);
        check("frames_ainfo", n_ainfo, 3 * AINFO_ON);
        check("frames_null", n_null, 0);
        check("frames_total", sel_log.size(), 4 + 3 * AINFO_ON);

        check("invariants", viol, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
